// File: rtl/irq_encoder83_pkg.sv
// Shared constants and types for the 8-to-3 interrupt request encoder.
package irq_encoder83_pkg;

    localparam int unsigned NUM_LINES = 8;
    localparam int unsigned CODE_W    = 3;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    // Request lines idle high, so the previous-sample register resets to all ones.
    function automatic logic [NUM_LINES-1:0] req_prev_rst();
        return {NUM_LINES{1'b1}};
    endfunction

endpackage

// File: rtl/irq_encoder83_if.sv
// Request/grant bundle between peripheral lines, the encoder and its consumer.
interface irq_encoder83_if;
    import irq_encoder83_pkg::*;

    logic [NUM_LINES-1:0] req_n;
    logic                 en;
    logic                 ack;
    logic                 clr_ovf;
    logic [CODE_W-1:0]    code;
    logic                 valid;
    logic                 any_pending;
    logic [NUM_LINES-1:0] ovf;

    // Driver of requests and consumer of codes.
    modport master (
        output req_n, en, ack, clr_ovf,
        input  code, valid, any_pending, ovf
    );

    // The encoder itself.
    modport slave (
        input  req_n, en, ack, clr_ovf,
        output code, valid, any_pending, ovf
    );

endinterface

// File: rtl/irq_encoder83_prio_enc83.sv
// Combinational 8-to-3 priority encoder, active-high; highest set bit wins, idx=0 when empty.
module prio_enc83
    import irq_encoder83_pkg::*;
(
    input  logic [NUM_LINES-1:0] mask,
    output logic [CODE_W-1:0]    idx,
    output logic                 any
);

    // Ascending scan so the last (highest) set bit overrides lower ones.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (mask[i]) begin
                idx = CODE_W'(i);
            end
        end
        any = |mask;
    end

endmodule

// File: rtl/irq_encoder83.sv
// Edge-captured 8-line request encoder with a valid/ack handshake and sticky overflow flags.
module irq_encoder83
    import irq_encoder83_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    irq_encoder83_if.slave bus
);

    logic [NUM_LINES-1:0] req_prev_q;
    logic                 primed_q;
    logic [NUM_LINES-1:0] pending_q, pending_d;
    logic [NUM_LINES-1:0] ovf_q, ovf_d;
    logic [NUM_LINES-1:0] fall, retire;
    state_t               state_q, state_d;
    logic [CODE_W-1:0]    code_q, code_d;
    logic [CODE_W-1:0]    top_idx;
    logic                 top_any;

    prio_enc83 u_prio (
        .mask (pending_q),
        .idx  (top_idx),
        .any  (top_any)
    );

    // Edge detect and pending/overflow update; a new falling edge beats a same-cycle retire.
    always_comb begin
        // Without a post-reset sample, a line held low through reset would look like an edge.
        fall      = primed_q ? (req_prev_q & ~bus.req_n) : '0;
        retire    = (state_q == BUSY && bus.ack) ? (NUM_LINES'(1) << code_q) : '0;
        pending_d = (pending_q & ~retire) | fall;
        ovf_d     = (bus.clr_ovf ? '0 : ovf_q) | (fall & pending_q & ~retire);
    end

    // Grant from IDLE when enabled; BUSY holds the code until acknowledged.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (bus.en && top_any) begin
                    code_d  = top_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_prev_q <= req_prev_rst();
            primed_q   <= 1'b0;
            pending_q  <= '0;
            ovf_q      <= '0;
        end else begin
            req_prev_q <= bus.req_n;
            primed_q   <= 1'b1;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
        end
    end

    // FSM state and presented code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
        end
    end

    assign bus.code        = code_q;
    assign bus.valid       = (state_q == BUSY);
    assign bus.any_pending = |pending_q;
    assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_irq_encoder83.sv
// Self-checking bench for irq_encoder83: directed scenarios plus randomized traffic vs a line model.
module tb_irq_encoder83;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    irq_encoder83_if bus ();

    irq_encoder83 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: per-line event bookkeeping and a single outstanding grant.
    logic [7:0] m_pend, m_ovf, m_prev;
    bit         m_primed, m_busy;
    int         m_code;

    task automatic model_reset();
        m_pend = '0; m_ovf = '0; m_prev = 8'hFF;
        m_primed = 0; m_busy = 0; m_code = 0;
    endtask

    task automatic model_edge();
        logic [7:0] np, no;
        bit fell, ret;
        for (int i = 0; i < 8; i++) begin
            fell  = m_primed && m_prev[i] && !bus.req_n[i];
            ret   = m_busy && bus.ack && (m_code == i);
            np[i] = fell || (m_pend[i] && !ret);
            no[i] = (fell && m_pend[i] && !ret) || (m_ovf[i] && !bus.clr_ovf);
        end
        if (m_busy) begin
            if (bus.ack) m_busy = 0;
        end else if (bus.en && m_pend != 0) begin
            for (int i = 7; i >= 0; i--) begin
                if (m_pend[i]) begin
                    m_code = i;
                    break;
                end
            end
            m_busy = 1;
        end
        m_pend = np; m_ovf = no; m_prev = bus.req_n; m_primed = 1;
    endtask

    // One clock: model follows the edge, outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        bus.req_n = 8'hFF; bus.en = 1'b1; bus.ack = 1'b0; bus.clr_ovf = 1'b0;
        rst = 1'b1;
        model_reset();
        #12;
        n_cmp++;
        if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.valid); end
        n_cmp++;
        if (bus.ovf !== 8'h00) begin n_fail++; $display("FAIL reset_ovf got %h want 00", bus.ovf); end
        n_cmp++;
        if (bus.any_pending !== 1'b0) begin n_fail++; $display("FAIL reset_any got %b want 0", bus.any_pending); end
        n_cmp++;
        if (bus.code !== 3'd0) begin n_fail++; $display("FAIL reset_code got %0d want 0", bus.code); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        bus.req_n = 8'hF7;
        step();
        bus.req_n = 8'hFF;
        n_cmp++;
        if (bus.any_pending !== 1'b1 || bus.valid !== 1'b0) begin
            n_fail++; $display("FAIL single_capture got any=%b valid=%b want 1/0", bus.any_pending, bus.valid);
        end
        step();
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.code !== 3'd3) begin
            n_fail++; $display("FAIL single_grant got valid=%b code=%0d want 1/3", bus.valid, bus.code);
        end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.any_pending !== 1'b0) begin
            n_fail++; $display("FAIL single_retire got valid=%b any=%b want 0/0", bus.valid, bus.any_pending);
        end
    endtask

    task automatic test_priority();
        int exp_codes[3] = '{5, 7, 1};
        bus.req_n = 8'hDD;
        step();
        bus.req_n = 8'hFF;
        step();
        bus.req_n = 8'h7F;
        step();
        bus.req_n = 8'hFF;
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.code !== 3'd5) begin
            n_fail++; $display("FAIL prio_no_preempt got valid=%b code=%0d want 1/5", bus.valid, bus.code);
        end
        for (int t = 0; t < 3; t++) begin
            if (t > 0) begin
                step();
                n_cmp++;
                if (bus.valid !== 1'b1 || bus.code !== 3'(exp_codes[t])) begin
                    n_fail++;
                    $display("FAIL prio_order got valid=%b code=%0d want 1/%0d", bus.valid, bus.code, exp_codes[t]);
                end
            end
            bus.ack = 1'b1;
            step();
            bus.ack = 1'b0;
            n_cmp++;
            if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL prio_gap got valid=%b want 0", bus.valid); end
        end
        n_cmp++;
        if (bus.any_pending !== 1'b0) begin n_fail++; $display("FAIL prio_drain got any=%b want 0", bus.any_pending); end
    endtask

    task automatic test_held_low();
        int txn = 0;
        bus.req_n = 8'hFB;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.valid === 1'b1 && bus.code === 3'd2) txn++;
            bus.ack = bus.valid;
        end
        bus.ack = 1'b0;
        bus.req_n = 8'hFF;
        step();
        n_cmp++;
        if (txn !== 1) begin n_fail++; $display("FAIL held_low_txns got %0d want 1", txn); end
    endtask

    task automatic test_overflow();
        int txn = 0;
        bus.req_n = 8'hFE; step();
        bus.req_n = 8'hFF; step();
        bus.req_n = 8'hFE; step();
        bus.req_n = 8'hFF; step();
        n_cmp++;
        if (bus.ovf !== 8'h01) begin n_fail++; $display("FAIL ovf_set got %h want 01", bus.ovf); end
        for (int c = 0; c < 6; c++) begin
            if (bus.valid === 1'b1 && bus.code === 3'd0) txn++;
            bus.ack = bus.valid;
            step();
        end
        bus.ack = 1'b0;
        n_cmp++;
        if (txn !== 1) begin n_fail++; $display("FAIL ovf_single_txn got %0d want 1", txn); end
        n_cmp++;
        if (bus.ovf !== 8'h01) begin n_fail++; $display("FAIL ovf_sticky got %h want 01", bus.ovf); end
        bus.clr_ovf = 1'b1; step(); bus.clr_ovf = 1'b0;
        n_cmp++;
        if (bus.ovf !== 8'h00) begin n_fail++; $display("FAIL ovf_clear got %h want 00", bus.ovf); end
    endtask

    task automatic test_en_gating();
        bus.en = 1'b0;
        bus.req_n = 8'hAF; step();
        bus.req_n = 8'hFF; step(); step();
        n_cmp++;
        if (bus.any_pending !== 1'b1 || bus.valid !== 1'b0) begin
            n_fail++; $display("FAIL en_block got any=%b valid=%b want 1/0", bus.any_pending, bus.valid);
        end
        bus.en = 1'b1; step();
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.code !== 3'd6) begin
            n_fail++; $display("FAIL en_first got valid=%b code=%0d want 1/6", bus.valid, bus.code);
        end
        bus.ack = 1'b1; step(); bus.ack = 1'b0;
        step();
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.code !== 3'd4) begin
            n_fail++; $display("FAIL en_second got valid=%b code=%0d want 1/4", bus.valid, bus.code);
        end
        bus.ack = 1'b1; step(); bus.ack = 1'b0;
    endtask

    task automatic test_collision();
        bus.req_n = 8'hF7; step();
        bus.req_n = 8'hFF; step();
        bus.req_n = 8'hF7; bus.ack = 1'b1; step();
        bus.req_n = 8'hFF; bus.ack = 1'b0;
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.any_pending !== 1'b1 || bus.ovf[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL collide_keep got valid=%b any=%b ovf3=%b want 0/1/0", bus.valid, bus.any_pending, bus.ovf[3]);
        end
        step();
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.code !== 3'd3) begin
            n_fail++; $display("FAIL collide_represent got valid=%b code=%0d want 1/3", bus.valid, bus.code);
        end
        bus.ack = 1'b1; step(); bus.ack = 1'b0;
    endtask

    task automatic test_async_reset();
        // Build an overflow on line 4 so reset has something to clear.
        bus.req_n = 8'hEF; step();
        bus.req_n = 8'hFF; step();
        bus.req_n = 8'hEF; step();
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.ovf !== 8'h10) begin
            n_fail++; $display("FAIL areset_setup got valid=%b ovf=%h want 1/10", bus.valid, bus.ovf);
        end
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.any_pending !== 1'b0 || bus.ovf !== 8'h00) begin
            n_fail++;
            $display("FAIL areset_async got valid=%b any=%b ovf=%h want 0/0/00", bus.valid, bus.any_pending, bus.ovf);
        end
        #1 rst = 1'b0;
        for (int c = 0; c < 4; c++) step();
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.any_pending !== 1'b0) begin
            n_fail++; $display("FAIL areset_held_low got valid=%b any=%b want 0/0", bus.valid, bus.any_pending);
        end
        bus.req_n = 8'hFF; step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 5) == 0) bus.req_n[i] = ~bus.req_n[i];
            end
            bus.en      = ($urandom_range(0, 9) < 8);
            bus.ack     = $urandom_range(0, 1) == 1;
            bus.clr_ovf = ($urandom_range(0, 19) == 0);
            step();
            n_cmp++;
            if (bus.valid !== m_busy || bus.any_pending !== (m_pend != 0) || bus.ovf !== m_ovf
                || (m_busy && bus.code !== 3'(m_code))) begin
                n_fail++;
                $display("FAIL random_c%0d got valid=%b code=%0d any=%b ovf=%h want %b/%0d/%b/%h", c,
                         bus.valid, bus.code, bus.any_pending, bus.ovf, m_busy, m_code, m_pend != 0, m_ovf);
            end
        end
        bus.ack = 1'b0; bus.clr_ovf = 1'b0; bus.en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_held_low();
        test_overflow();
        test_en_gating();
        test_collision();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
